// File: rtl/o_serdes_clk_ctrl.sv
// Clock sequencer for the output serializer clock primitive: PLL lock qualification,
// clock-gate control and glitch-safe phase switching behind a valid/ack handshake.
module o_serdes_clk_ctrl #(
    parameter int unsigned LOCK_WAIT_CYCLES = 256,
    parameter int unsigned GAP_CYCLES       = 4,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PLL_LOCK,
    input  logic       EN,
    input  logic       PHASE_VALID,
    input  logic [1:0] PHASE_IN,
    input  logic       CLR_ERR,
    output logic       CLK_EN,
    output logic [1:0] PHASE_SEL,
    output logic       PHASE_ACK,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_NO_LOCK   = 3'd0,
        S_STABILIZE = 3'd1,
        S_IDLE      = 3'd2,
        S_RUN       = 3'd3,
        S_GAP       = 3'd4
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(LOCK_WAIT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [7:0]             gcnt_q, gcnt_d;
    logic                   clk_en_q, clk_en_d;
    logic [1:0]             phase_sel_q, phase_sel_d;
    logic                   ack_q, ack_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lock_s;
    logic                   req;
    logic                   gap_done;
    logic                   lost_set;

    // Handshake: a request is PHASE_VALID held high with PHASE_IN stable until PHASE_ACK
    // pulses for one cycle; VALID seen during the ack cycle is the same request, not a new one.
    assign req      = PHASE_VALID && !ack_q;
    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign gap_done = (gcnt_q == GAP_LAST);
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], PLL_LOCK};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_NO_LOCK;
            sync_q      <= '0;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            clk_en_q    <= 1'b0;
            phase_sel_q <= 2'd0;
            ack_q       <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            clk_en_q    <= clk_en_d;
            phase_sel_q <= phase_sel_d;
            ack_q       <= ack_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NO_LOCK: begin
                if (lock_s) state_d = S_STABILIZE;
            end
            S_STABILIZE: begin
                if (!lock_s)                state_d = S_NO_LOCK;
                else if (cnt_q == CNT_LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!lock_s)  state_d = S_NO_LOCK;
                else if (EN)  state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s)                             state_d = S_NO_LOCK;
                else if (!EN)                            state_d = S_IDLE;
                else if (req && PHASE_IN != phase_sel_q) state_d = S_GAP;
            end
            S_GAP: begin
                if (!lock_s)       state_d = S_NO_LOCK;
                else if (gap_done) state_d = EN ? S_RUN : S_IDLE;
            end
            default: state_d = S_NO_LOCK;
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        gcnt_d      = '0;
        clk_en_d    = clk_en_q;
        phase_sel_d = phase_sel_q;
        ack_d       = 1'b0;
        ready_d     = ready_q;
        lost_set    = 1'b0;
        unique case (state_q)
            S_NO_LOCK: begin
                ready_d  = 1'b0;
                clk_en_d = 1'b0;
            end
            S_STABILIZE: begin
                if (lock_s) begin
                    if (cnt_q == CNT_LAST) ready_d = 1'b1;
                    else                   cnt_d   = cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                clk_en_d = 1'b0;
                if (!lock_s) begin
                    ready_d  = 1'b0;
                    lost_set = 1'b1;
                end else begin
                    // Clock is already stopped, so a phase change needs no gap here.
                    if (req) begin
                        phase_sel_d = PHASE_IN;
                        ack_d       = 1'b1;
                    end
                    if (EN) clk_en_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    ready_d  = 1'b0;
                    clk_en_d = 1'b0;
                    lost_set = 1'b1;
                end else if (!EN) begin
                    clk_en_d = 1'b0;
                end else if (req) begin
                    if (PHASE_IN == phase_sel_q) ack_d    = 1'b1;
                    else                         clk_en_d = 1'b0;
                end
            end
            S_GAP: begin
                clk_en_d = 1'b0;
                if (!lock_s) begin
                    ready_d  = 1'b0;
                    lost_set = 1'b1;
                end else if (gap_done) begin
                    phase_sel_d = PHASE_IN;
                    ack_d       = 1'b1;
                    clk_en_d    = EN;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: begin
                ready_d  = 1'b0;
                clk_en_d = 1'b0;
            end
        endcase
        // A new loss wins over a clear arriving in the same cycle.
        if (lost_set)     lock_lost_d = 1'b1;
        else if (CLR_ERR) lock_lost_d = 1'b0;
        else              lock_lost_d = lock_lost_q;
    end

    assign CLK_EN    = clk_en_q;
    assign PHASE_SEL = phase_sel_q;
    assign PHASE_ACK = ack_q;
    assign READY     = ready_q;
    assign LOCK_LOST = lock_lost_q;
    assign state_dbg = state_q;

endmodule

// File: doc/o_serdes_clk_ctrl.md
Name: o_serdes_clk_ctrl

Overview:
Synthesizable sequencer for the output serializer clock primitive.
- Synchronizes PLL_LOCK and requires it to stay high for LOCK_WAIT_CYCLES before declaring ready.
- Drives the primitive's clock-gate input (CLK_EN) and a registered phase select (PHASE_SEL).
- Phase changes run through a glitch-safe gated gap behind a valid/ack handshake.
- Sits between fabric control logic and the serializer clock primitive, in the CLK (system clock) domain.

Parameters:
LOCK_WAIT_CYCLES, 256, CLK cycles PLL lock must stay stable before READY; range 2..65535.
GAP_CYCLES, 4, CLK cycles CLK_EN is held low around a phase change; range 1..255.
SYNC_STAGES, 2, flop stages on the PLL_LOCK synchronizer; range 2..4.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  reset; asynchronous assert, active-low; all registers cleared while low.
PLL_LOCK  input  1  PLL lock, asynchronous to CLK.
EN  input  1  requester wants the output clock running.
PHASE_VALID  input  1  phase change request; held high until PHASE_ACK.
PHASE_IN  input  2  requested phase: 0=0deg, 1=90, 2=180, 3=270; stable while PHASE_VALID is high.
CLR_ERR  input  1  clears LOCK_LOST.
CLK_EN  output  1  clock-gate enable to the serializer clock primitive.
PHASE_SEL  output  2  applied phase code.
PHASE_ACK  output  1  one-cycle pulse: request applied.
READY  output  1  lock stable; controller accepts requests.
LOCK_LOST  output  1  sticky: lock dropped after READY.

Behaviour:
- Reset values: all outputs 0; state NO_LOCK; counters 0; synchronizer flops 0. All outputs are registered.
- lock_s is PLL_LOCK after SYNC_STAGES flops.
- States: NO_LOCK, STABILIZE, IDLE, RUN, GAP.
- Priority within a cycle: lock_s=0 (states other than NO_LOCK) > GAP completion > EN/PHASE_VALID.
- NO_LOCK:
  - READY=0, CLK_EN=0, counter cleared.
  - lock_s=1 -> STABILIZE with cnt=0.
- STABILIZE:
  - cnt increments each edge.
  - lock_s=0 -> NO_LOCK, cnt=0; LOCK_LOST not set.
  - cnt==LOCK_WAIT_CYCLES-1 with lock_s=1 -> IDLE, READY<=1.
  - Net effect: READY rises on the (SYNC_STAGES+LOCK_WAIT_CYCLES+1)th edge after PLL_LOCK rises.
- IDLE:
  - CLK_EN=0.
  - PHASE_VALID=1 -> PHASE_SEL<=PHASE_IN and PHASE_ACK<=1 on the same edge; no gap is needed.
  - EN=1 -> RUN, CLK_EN<=1. A simultaneous phase request is applied on the same edge.
- RUN:
  - CLK_EN=1.
  - EN=0 -> IDLE, CLK_EN<=0.
  - PHASE_VALID with PHASE_IN==PHASE_SEL -> PHASE_ACK<=1, stay in RUN, CLK_EN unchanged.
  - PHASE_VALID with PHASE_IN!=PHASE_SEL -> GAP, CLK_EN<=0, gcnt=0.
- GAP:
  - CLK_EN=0; gcnt increments each edge.
  - When gcnt==GAP_CYCLES-1: PHASE_SEL<=PHASE_IN, PHASE_ACK<=1, CLK_EN<=EN, next state RUN if EN else IDLE.
  - Result: CLK_EN is low for exactly GAP_CYCLES cycles.
  - EN changes during GAP are sampled only at completion.
- Handshake:
  - PHASE_ACK is a single-cycle pulse.
  - A PHASE_VALID still high in the cycle PHASE_ACK is high is the same request and is not re-acked.
  - In NO_LOCK and STABILIZE, requests wait un-acked.
- Lock loss (lock_s=0 in IDLE, RUN or GAP):
  - Next edge: NO_LOCK, READY=0, CLK_EN=0, LOCK_LOST<=1.
  - A pending GAP request is dropped un-acked; PHASE_SEL keeps its old value.
  - Re-lock repeats the full STABILIZE count.
- LOCK_LOST:
  - Cleared by CLR_ERR=1.
  - Set beats clear when both occur in the same cycle.
- Reset mid-operation: CLK_EN and all outputs go low asynchronously, with no glitch pulse.

Test Plan:
1. LOCK_WAIT_CYCLES=8, SYNC_STAGES=2; raise PLL_LOCK before edge 0 -> READY=1 after edge 10, never earlier; CLK_EN stays 0 with EN=0.
2. PLL_LOCK drops for one cycle during STABILIZE (cnt=5) -> returns to NO_LOCK; READY delayed by the full recount; LOCK_LOST=0.
3. RUN with PHASE_SEL=0, EN=1; request PHASE_IN=2 -> CLK_EN low for exactly 4 cycles (GAP_CYCLES=4); PHASE_SEL=2 and a one-cycle PHASE_ACK on the re-enable edge; no second ack while VALID is still held.
4. RUN, request PHASE_IN equal to current PHASE_SEL -> PHASE_ACK on the next edge; CLK_EN never drops.
5. PLL_LOCK drops during GAP (gcnt=1) -> NO_LOCK, CLK_EN=0, READY=0, LOCK_LOST=1; PHASE_SEL unchanged; no ack. CLR_ERR asserted together with a new loss -> LOCK_LOST stays 1.
6. Assert RST low mid-RUN asynchronously -> CLK_EN, READY, PHASE_SEL and PHASE_ACK are 0 immediately; after release the full lock sequence repeats.
